// File: rtl/ll_fifo_pkg.sv
// Shared definitions for the linked-list FIFO slice: select-width helper and round-robin next-grant search.
package ll_fifo_pkg;

  localparam int unsigned MAX_FIFOS = 64;
  localparam int unsigned IDX_W     = 6;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } grant_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Search starts one past the last grant and wraps modulo n; idx falls back to last when nothing is requesting.
  function automatic grant_t rr_next(input logic [MAX_FIFOS-1:0] req,
                                     input int unsigned last,
                                     input int unsigned n);
    grant_t      g;
    int unsigned k;
    g.valid = 1'b0;
    g.idx   = last[IDX_W-1:0];
    for (int unsigned i = 1; i <= MAX_FIFOS; i++) begin
      k = (last + i) % n;
      if (i <= n && !g.valid && req[k]) begin
        g.valid = 1'b1;
        g.idx   = k[IDX_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus last grant in, grant index and valid out.
module rr_arbiter
  import ll_fifo_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = 2,
  parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [SEL_WIDTH-1:0] last_grant,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 valid
);

  logic [MAX_FIFOS-1:0] req_ext;
  grant_t               g;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_FIFOS-1:0] = req;
    g                      = rr_next(req_ext, 32'(last_grant), NUM_FIFOS);
    valid                  = g.valid;
    grant                  = SEL_WIDTH'(g.idx);
  end

endmodule

// File: rtl/ll_fifo_drain_arb.sv
// Round-robin drain of a shared linked-list FIFO into a valid/ready output stage.
// Define LL_DRAIN_SKID_EN for a one-entry skid register that removes the out_ready -> pop path.
module ll_fifo_drain_arb
  import ll_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NUM_FIFOS = 2,
  parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [WIDTH-1:0]     data_out,
  input  logic [NUM_FIFOS-1:0] drain_en,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel
);

  logic [NUM_FIFOS-1:0] eligible;
  logic [SEL_WIDTH-1:0] last_grant;
  logic [SEL_WIDTH-1:0] grant;
  logic                 grant_valid;

  always_comb eligible = ~empty & drain_en;

  rr_arbiter #(
    .NUM_FIFOS(NUM_FIFOS),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_arb (
    .req       (eligible),
    .last_grant(last_grant),
    .grant     (grant),
    .valid     (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst)      last_grant <= SEL_WIDTH'(NUM_FIFOS - 1);
    else if (pop) last_grant <= pop_sel;
  end

`ifdef LL_DRAIN_SKID_EN
  logic                 skid_valid;
  logic [WIDTH-1:0]     skid_data;
  logic [SEL_WIDTH-1:0] skid_sel;

  always_comb begin
    pop     = grant_valid & ~skid_valid & ~rst;
    pop_sel = grant;
  end

  // Skid is only filled while the output is stalled, so it always holds the younger word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
    end else if (~out_valid | out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_sel    <= skid_sel;
        skid_valid <= 1'b0;
      end else if (pop) begin
        out_valid <= 1'b1;
        out_data  <= data_out;
        out_sel   <= pop_sel;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (pop) begin
      skid_valid <= 1'b1;
      skid_data  <= data_out;
      skid_sel   <= pop_sel;
    end
  end
`else
  always_comb begin
    pop     = grant_valid & (~out_valid | out_ready) & ~rst;
    pop_sel = grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= data_out;
      out_sel   <= pop_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/ll_fifo_drain_arb.md
LL_FIFO_DRAIN_ARB -- requirements
Module: ll_fifo_drain_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data word width, equal to the shared linked-list FIFO's WIDTH.
REQ-002 SHALL have parameter NUM_FIFOS, default 2: number of logical queues in the shared FIFO.
REQ-003 SHALL have parameter SEL_WIDTH, default max(1, clog2(NUM_FIFOS)): queue-select width.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port empty, input, NUM_FIFOS: per-queue empty flags from the shared FIFO.
REQ-007 SHALL have port data_out, input, WIDTH: shared FIFO head data for pop_sel, valid combinationally in the pop cycle.
REQ-008 SHALL have port drain_en, input, NUM_FIFOS: per-queue drain enable mask.
REQ-009 SHALL have port pop, output, 1: pop strobe to the shared FIFO.
REQ-010 SHALL have port pop_sel, output, SEL_WIDTH: queue popped.
REQ-011 SHALL have port out_valid, output, 1: output word valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the output word.
REQ-013 SHALL have port out_data, output, WIDTH: output word.
REQ-014 SHALL have port out_sel, output, SEL_WIDTH: source queue of out_data.

Function
REQ-015 SHALL treat queue q as eligible when ~empty[q] & drain_en[q].
REQ-016 SHALL never assert pop with empty[pop_sel]=1; this is the shared FIFO's pop precondition.
REQ-017 SHALL grant round-robin: search starts at last_grant+1, wraps modulo NUM_FIFOS, and the first eligible queue wins.
REQ-018 SHALL update last_grant only in a cycle where pop=1.
REQ-019 SHALL, in the base build, assert pop iff an eligible queue exists and (~out_valid | out_ready).
REQ-020 SHALL capture data_out and pop_sel into out_data and out_sel on the pop edge, so out_valid rises one cycle after pop.
REQ-021 SHALL hold out_data and out_sel stable while out_valid & ~out_ready.
REQ-022 SHALL, on a cycle with out_valid & out_ready and no pop, deassert out_valid next cycle.
REQ-023 SHALL, on a cycle with out_valid & out_ready & pop, present the new word next cycle with no bubble.
REQ-024 SHALL, when no queue is eligible, hold pop=0 and pop_sel at last_grant.
REQ-025 SHALL, for NUM_FIFOS=1, always select queue 0.

Reset
REQ-026 SHALL on rst clear out_valid, pop, out_data, out_sel and all skid state, and set last_grant=NUM_FIFOS-1, so the first grant goes to queue 0.
REQ-027 SHALL on rst mid-transfer discard any held word, without a pop in the reset cycle.

Configuration
REQ-028 SHALL, with macro LL_DRAIN_SKID_EN defined, add a one-entry skid register: pop is gated by ~skid_valid only (registered, no out_ready combinational path), and a word arriving while out_valid & ~out_ready goes to skid, then moves to output on the next out_ready.
REQ-029 SHALL, without LL_DRAIN_SKID_EN, implement the single output register of REQ-019 to REQ-023.
REQ-030 SHALL preserve order per queue and never lose or duplicate a word in both builds.

Structure
REQ-031 SHALL take the SEL_WIDTH computation and the round-robin next-grant function from a shared package ll_fifo_pkg, which the FIFO proof top also uses.
REQ-032 SHALL instantiate one sub-module, rr_arbiter (request vector, last_grant to grant index, valid), which is purely combinational; the output and skid registers stay in the parent.

Verification
REQ-033 SHALL cover: NUM_FIFOS=2, both queues non-empty, out_ready=1 -> pop_sel 0,1,0,1 on consecutive cycles with out_valid continuous from cycle 2.
REQ-034 SHALL cover: queue 1 empty, queue 0 holds 3 words (A,B,C) -> three pops on sel 0, out_data A,B,C, then pop=0.
REQ-035 SHALL cover: out_ready=0 for 4 cycles with data pending -> base build issues exactly 1 pop, skid build exactly 2, and out_data is held.
REQ-036 SHALL cover: drain_en=2'b01 with both queues non-empty -> only sel 0 popped.
REQ-037 SHALL cover: rst asserted while out_valid=1 -> next cycle out_valid=0 and the next pop_sel=0.
REQ-038 SHALL cover: random traffic against the shared FIFO -> the empty-pop assertion never fires and a per-queue scoreboard matches.
